// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: decode constants and the resolved-branch record.
package bp_pkg;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP        = 32'h00000013;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        valid;
    } bp_update_t;
endpackage

// File: rtl/branch_history_table_if.sv
// Predict/update/statistics bundle between the pipeline (master) and the branch history table (slave).
interface branch_history_table_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] pred_pc;
    logic [XLEN-1:0] pred_imm;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic            upd_mispredict;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;

    modport master (
        output pred_pc, pred_imm, upd_valid, upd_pc, upd_taken,
        input  pred_taken, pred_target, upd_mispredict, stat_branches, stat_mispredicts
    );
    modport slave (
        input  pred_pc, pred_imm, upd_valid, upd_pc, upd_taken,
        output pred_taken, pred_target, upd_mispredict, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_history_table_sat_counter_step.sv
// One saturating-counter step: next value for a resolved outcome, plus whether the old MSB disagreed.
module sat_counter_step #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] c,
    input  logic             taken,
    output logic [CTR_W-1:0] c_next,
    output logic             mispredict
);
    localparam logic [CTR_W-1:0] MAX = '1;

    always_comb begin
        c_next = c;
        if (taken) begin
            if (c != MAX) c_next = c + CTR_W'(1);
        end else begin
            if (c != '0) c_next = c - CTR_W'(1);
        end
        mispredict = c[CTR_W-1] != taken;
    end
endmodule

// File: rtl/branch_history_table.sv
// PC-indexed table of saturating direction counters with combinational predict and registered update.
// Optional statistics counters are built when BHT_STATS_EN is defined.
module branch_history_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int INIT    = 1,
    parameter int XLEN    = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic freeze_cpu,
    branch_history_table_if.slave bus
);
    localparam int               IDX_W  = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] INIT_V = CTR_W'(INIT);

    logic [CTR_W-1:0] ctr [ENTRIES];
    logic [IDX_W-1:0] pred_idx, upd_idx;
    logic [CTR_W-1:0] step_next;
    logic             step_misp;
    logic             accept;
    logic             mispredict;

    assign pred_idx = bus.pred_pc[IDX_W+1:2];
    assign upd_idx  = bus.upd_pc[IDX_W+1:2];
    assign accept   = bus.upd_valid && !freeze_cpu;

    // Read is from the current table: a same-cycle update to this index is not bypassed.
    assign bus.pred_taken  = ctr[pred_idx][CTR_W-1];
    assign bus.pred_target = bus.pred_taken ? bus.pred_pc + bus.pred_imm
                                            : bus.pred_pc + XLEN'(4);

    sat_counter_step #(.CTR_W(CTR_W)) u_step (
        .c          (ctr[upd_idx]),
        .taken      (bus.upd_taken),
        .c_next     (step_next),
        .mispredict (step_misp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= INIT_V;
            mispredict <= 1'b0;
        end else if (!freeze_cpu) begin
            mispredict <= accept && step_misp;
            if (accept) ctr[upd_idx] <= step_next;
        end
    end

    assign bus.upd_mispredict = mispredict;

`ifdef BHT_STATS_EN
    logic [31:0] stat_br, stat_mp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br <= '0;
            stat_mp <= '0;
        end else if (accept) begin
            if (stat_br != '1)              stat_br <= stat_br + 32'd1;
            if (step_misp && stat_mp != '1) stat_mp <= stat_mp + 32'd1;
        end
    end

    assign bus.stat_branches    = stat_br;
    assign bus.stat_mispredicts = stat_mp;
`else
    assign bus.stat_branches    = '0;
    assign bus.stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table: directed scenarios plus randomized traffic vs a counter-array model.
module tb_branch_history_table;
    localparam int ENTRIES = 64;
    localparam int CTR_W   = 2;
    localparam int INIT    = 1;
    localparam int MAXC    = (1 << CTR_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic freeze_cpu = 1'b0;

    branch_history_table_if #(.XLEN(32)) bus ();

    branch_history_table #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .INIT(INIT), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze_cpu (freeze_cpu),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int          model [ENTRIES];
    logic        exp_misp;
    logic [31:0] exp_br, exp_mp;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic m_taken(input logic [31:0] pc);
        return model[idx(pc)] >= (1 << (CTR_W - 1));
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc, input logic [31:0] imm);
        return m_taken(pc) ? pc + imm : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) model[i] = INIT;
        exp_misp = 1'b0;
        exp_br   = '0;
        exp_mp   = '0;
    endtask

    // Advance one clock, applying the specified update rules to the model for the edge.
    task automatic tick();
        int  c;
        logic mp;
        if (!freeze_cpu) begin
            if (bus.upd_valid) begin
                c  = model[idx(bus.upd_pc)];
                mp = (c >= (1 << (CTR_W - 1))) != bus.upd_taken;
                exp_misp = mp;
                model[idx(bus.upd_pc)] = bus.upd_taken ? ((c < MAXC) ? c + 1 : c)
                                                       : ((c > 0) ? c - 1 : c);
                if (exp_br != 32'hFFFFFFFF) exp_br = exp_br + 1;
                if (mp && exp_mp != 32'hFFFFFFFF) exp_mp = exp_mp + 1;
            end else begin
                exp_misp = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic t);
        bus.upd_valid = v;
        bus.upd_pc    = pc;
        bus.upd_taken = t;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_upd(1'b0, 32'h0, 1'b0);
        bus.pred_pc  = 32'h40;
        bus.pred_imm = 32'h10;
        model_reset();
        #12;
        n_checks++;
        if (bus.pred_taken !== 1'b0) $display("FAIL reset_pred_taken got %0b want 0", bus.pred_taken);
        else n_pass++;
        n_checks++;
        if (bus.pred_target !== 32'h44) $display("FAIL reset_pred_target got %h want 00000044", bus.pred_target);
        else n_pass++;
        n_checks++;
        if (bus.upd_mispredict !== 1'b0) $display("FAIL reset_mispredict got %0b want 0", bus.upd_mispredict);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_taken_twice();
        logic want [3] = '{1'b1, 1'b0, 1'b0};
        set_upd(1'b1, 32'h40, 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) set_upd(1'b0, 32'h40, 1'b1);
            tick();
            n_checks++;
            if (bus.upd_mispredict !== want[k])
                $display("FAIL taken_twice_misp[%0d] got %0b want %0b", k, bus.upd_mispredict, want[k]);
            else n_pass++;
        end
        bus.pred_pc = 32'h40; bus.pred_imm = 32'h10; #1;
        n_checks++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h50)
            $display("FAIL taken_twice_pred got %0b/%h want 1/00000050", bus.pred_taken, bus.pred_target);
        else n_pass++;
        bus.pred_pc = 32'h44; #1;
        n_checks++;
        if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h48)
            $display("FAIL neighbour_pred got %0b/%h want 0/00000048", bus.pred_taken, bus.pred_target);
        else n_pass++;
    endtask

    task automatic test_alias();
        bus.pred_pc = 32'h140; bus.pred_imm = 32'h20; #1;
        n_checks++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h160)
            $display("FAIL alias_0x140 got %0b/%h want 1/00000160", bus.pred_taken, bus.pred_target);
        else n_pass++;
        bus.pred_pc = 32'h144; #1;
        n_checks++;
        if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h148)
            $display("FAIL alias_0x144 got %0b/%h want 0/00000148", bus.pred_taken, bus.pred_target);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        bus.pred_pc = 32'h80; bus.pred_imm = 32'h8;
        set_upd(1'b1, 32'h80, 1'b1);
        #1;
        n_checks++;
        if (bus.pred_taken !== 1'b0) $display("FAIL same_cycle_old got %0b want 0", bus.pred_taken);
        else n_pass++;
        tick();
        set_upd(1'b0, 32'h0, 1'b0);
        #1;
        n_checks++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h88)
            $display("FAIL same_cycle_new got %0b/%h want 1/00000088", bus.pred_taken, bus.pred_target);
        else n_pass++;
        tick();
    endtask

    task automatic test_freeze_and_reset();
        logic [31:0] pcs [3] = '{32'h40, 32'h80, 32'h300};
        logic [31:0] br0, mp0;
        br0 = bus.stat_branches;
        mp0 = bus.stat_mispredicts;
        freeze_cpu = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_upd(1'b1, pcs[k], k[0]);
            tick();
            n_checks++;
            if (bus.upd_mispredict !== 1'b0) $display("FAIL freeze_misp[%0d] got %0b want 0", k, bus.upd_mispredict);
            else n_pass++;
        end
        freeze_cpu = 1'b0;
        set_upd(1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            bus.pred_pc = pcs[k]; #1;
            n_checks++;
            if (bus.pred_taken !== m_taken(pcs[k]))
                $display("FAIL freeze_table[%0d] got %0b want %0b", k, bus.pred_taken, m_taken(pcs[k]));
            else n_pass++;
        end
        n_checks++;
        if (bus.stat_branches !== br0 || bus.stat_mispredicts !== mp0)
            $display("FAIL freeze_stats got %0d/%0d want %0d/%0d", bus.stat_branches, bus.stat_mispredicts, br0, mp0);
        else n_pass++;
        // Update in flight, then asynchronous reset before its edge.
        set_upd(1'b1, 32'h40, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        bus.pred_pc = 32'h40; bus.pred_imm = 32'h10; #1;
        n_checks++;
        if (bus.pred_taken !== 1'b0 || bus.upd_mispredict !== 1'b0)
            $display("FAIL midreset got %0b/%0b want 0/0", bus.pred_taken, bus.upd_mispredict);
        else n_pass++;
        @(posedge clk); #1;
        set_upd(1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        bus.pred_pc = 32'h80; #1;
        n_checks++;
        if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h84)
            $display("FAIL post_reset_init got %0b/%h want 0/00000084", bus.pred_taken, bus.pred_target);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] pool [6] = '{32'h40, 32'h44, 32'h140, 32'h80, 32'h1FC, 32'h3000};
        for (int n = 0; n < 300; n++) begin
            bus.pred_pc  = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
            bus.pred_imm = $urandom;
            freeze_cpu   = ($urandom_range(0, 4) == 0);
            set_upd($urandom_range(0, 3) != 0, pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            #1;
            n_checks++;
            if (bus.pred_taken !== m_taken(bus.pred_pc) || bus.pred_target !== m_target(bus.pred_pc, bus.pred_imm))
                $display("FAIL rand_pred[%0d] pc=%h got %0b/%h want %0b/%h", n, bus.pred_pc,
                         bus.pred_taken, bus.pred_target, m_taken(bus.pred_pc), m_target(bus.pred_pc, bus.pred_imm));
            else n_pass++;
            tick();
            n_checks++;
            if (bus.upd_mispredict !== exp_misp)
                $display("FAIL rand_misp[%0d] got %0b want %0b", n, bus.upd_mispredict, exp_misp);
            else n_pass++;
        end
        freeze_cpu = 1'b0;
        set_upd(1'b0, 32'h0, 1'b0);
        n_checks++;
`ifdef BHT_STATS_EN
        if (bus.stat_branches !== exp_br || bus.stat_mispredicts !== exp_mp)
            $display("FAIL rand_stats got %0d/%0d want %0d/%0d", bus.stat_branches, bus.stat_mispredicts, exp_br, exp_mp);
        else n_pass++;
`else
        if (bus.stat_branches !== 32'h0 || bus.stat_mispredicts !== 32'h0)
            $display("FAIL stats_tied got %h/%h want 0/0", bus.stat_branches, bus.stat_mispredicts);
        else n_pass++;
`endif
    endtask

`ifdef BHT_STATS_EN
    task automatic test_stats();
        logic outcome [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_upd(1'b1, 32'h200, outcome[k]);
            tick();
        end
        set_upd(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (bus.stat_branches !== 32'd5 || bus.stat_mispredicts !== 32'd2)
            $display("FAIL stats_five got %0d/%0d want 5/2", bus.stat_branches, bus.stat_mispredicts);
        else n_pass++;
        force dut.stat_br = 32'hFFFFFFFE;
        @(posedge clk); #1;
        release dut.stat_br;
        exp_br = 32'hFFFFFFFE;
        for (int k = 0; k < 3; k++) begin
            set_upd(1'b1, 32'h200, 1'b1);
            tick();
        end
        set_upd(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (bus.stat_branches !== 32'hFFFFFFFF || bus.stat_branches !== exp_br)
            $display("FAIL stats_saturate got %h want ffffffff", bus.stat_branches);
        else n_pass++;
    endtask
`endif

    initial begin
        fork
            begin
                test_reset();
                test_taken_twice();
                test_alias();
                test_same_cycle();
                test_freeze_and_reset();
                test_random();
`ifdef BHT_STATS_EN
                test_stats();
`endif
            end
            begin
                #200000;
                $display("FAIL timeout got running want finished");
                n_checks++;
            end
        join_any
        disable fork;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
